// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: fixed-point constants (Q2.16, scale 65536),
// the arctangent table and the controller state encoding. Used by both the
// rotation-mode and vectoring-mode CORDIC blocks.
package cordic_pkg;

  localparam int unsigned FRAC   = 16;
  localparam int          PI_2   = 102944;
  localparam int          PI     = 205887;
  localparam int          K_GAIN = 39797;  // 1/An = 0.607253 in Q0.16

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_COMP   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // atan(2^-i) in Q2.16, i = 0..15
  function automatic int atan_lut(input logic [3:0] i);
    int a;
    case (i)
      4'd0:    a = 51472;
      4'd1:    a = 30386;
      4'd2:    a = 16055;
      4'd3:    a = 8150;
      4'd4:    a = 4091;
      4'd5:    a = 2047;
      4'd6:    a = 1024;
      4'd7:    a = 512;
      4'd8:    a = 256;
      4'd9:    a = 128;
      4'd10:   a = 64;
      4'd11:   a = 32;
      4'd12:   a = 16;
      4'd13:   a = 8;
      4'd14:   a = 4;
      default: a = 2;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// Single combinational vectoring-mode micro-rotation: drives y toward zero.
// Ports:
//   x, y  : current vector, signed, XW bits
//   z     : accumulated angle, signed, ZW bits
//   i     : iteration index (shift amount and atan table index)
//   x_c, y_c, z_c : rotated vector and updated angle
module cordic_vec_step
  import cordic_pkg::*;
#(
  parameter int unsigned XW = 20,
  parameter int unsigned ZW = 19
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [3:0]    i,
  output logic signed [XW-1:0] x_c,
  output logic signed [XW-1:0] y_c,
  output logic signed [ZW-1:0] z_c
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [ZW-1:0] a;

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign a  = ZW'(atan_lut(i));

  // Rotate clockwise when y is non-negative, counter-clockwise otherwise
  always_comb begin
    x_c = x;
    y_c = y;
    z_c = z;
    if (!y[XW-1]) begin
      x_c = x + ys;
      y_c = y - xs;
      z_c = z + a;
    end else begin
      x_c = x - ys;
      y_c = y + xs;
      z_c = z - a;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: returns atan2(y, x) and magnitude of a
// Q2.16 input vector, one micro-rotation per clock.
// Optional feature macro: CORDIC_GAIN_COMP_EN adds a COMP cycle that scales
// the magnitude by 1/An; without it mag_out carries the CORDIC gain (~1.64676).
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   init           : high loads/holds inputs; first low edge starts iterating
//   x_in, y_in     : signed Q2.16 vector components in [-1, 1)
//   angle_out      : signed Q3.16 radians in (-pi, pi]
//   mag_out        : signed Q3.16 magnitude
//   done           : high while angle_out/mag_out hold a valid result
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 16,
  parameter int unsigned W    = 18
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                init,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic signed [W:0]   angle_out,
  output logic signed [W:0]   mag_out,
  output logic                done
);

  localparam int unsigned XW = W + 2;
  localparam int unsigned ZW = W + 1;
  localparam int unsigned CW = 4;

  state_t               state;
  logic signed [XW-1:0] x;
  logic signed [XW-1:0] y;
  logic signed [ZW-1:0] z;
  logic        [CW-1:0] i;

  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] y_ext;
  logic signed [XW-1:0] x_ld;
  logic signed [XW-1:0] y_ld;
  logic signed [ZW-1:0] z_ld;

  logic signed [XW-1:0] x_c;
  logic signed [XW-1:0] y_c;
  logic signed [ZW-1:0] z_c;

  assign x_ext = XW'(x_in);
  assign y_ext = XW'(y_in);

  // Quadrant pre-rotation by +/-pi/2 moves left-half-plane vectors into x >= 0
  always_comb begin
    x_ld = x_ext;
    y_ld = y_ext;
    z_ld = '0;
    if (x_in[W-1]) begin
      if (!y_in[W-1]) begin
        x_ld = y_ext;
        y_ld = -x_ext;
        z_ld = ZW'(PI_2);
      end else begin
        x_ld = -y_ext;
        y_ld = x_ext;
        z_ld = ZW'(-PI_2);
      end
    end
  end

  cordic_vec_step #(
    .XW (XW),
    .ZW (ZW)
  ) u_step (
    .x   (x),
    .y   (y),
    .z   (z),
    .i   (i),
    .x_c (x_c),
    .y_c (y_c),
    .z_c (z_c)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned PW = XW + 18;
  localparam logic signed [17:0] K_S = 18'(K_GAIN);

  logic signed [PW-1:0] prod_c;

  assign prod_c = PW'(x) * PW'(K_S);
`endif

  // Controller: init has priority in every state (load or abort)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_LOAD;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
      angle_out <= '0;
      mag_out   <= '0;
      done      <= 1'b0;
    end else if (init) begin
      state <= ST_LOAD;
      x     <= x_ld;
      y     <= y_ld;
      z     <= z_ld;
      i     <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        // LOAD performs iteration 0 on the same edge it leaves
        ST_LOAD, ST_ROTATE: begin
          x <= x_c;
          y <= y_c;
          z <= z_c;
          i <= i + CW'(1);
          if (i == CW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= ST_COMP;
`else
            state     <= ST_DONE;
            angle_out <= z_c;
            mag_out   <= ZW'(x_c);
            done      <= 1'b1;
`endif
          end else begin
            state <= ST_ROTATE;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_COMP: begin
          state     <= ST_DONE;
          angle_out <= z;
          mag_out   <= ZW'(prod_c >>> FRAC);
          done      <= 1'b1;
        end
`endif
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
